// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, data LSB first from an external
// serializer, optional parity, stop bit.
// Optional build macro UART_TX_B2B_EN: drops busy during STOP so a waiting
// word can be accepted there and its START follows STOP with no idle cycle.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int WDOG_W     = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  TX_OUT,
    output logic                  frame_err
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              par_bit_q, par_en_q;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              frame_err_q, frame_err_d;
    logic              accept;
    logic              wdog_exp;

    // The external serializer loads on the same edge, keyed off the same busy.
    assign accept   = Data_Valid && !busy;
    // Counter holds cycles already spent in DATA; this is the last allowed one.
    assign wdog_exp = (wdog_q == WDOG_W'(DATA_WIDTH - 1));

    // Line, handshake and shift-enable outputs decoded from the state register.
    always_comb begin
        TX_OUT = 1'b1;
        busy   = 1'b0;
        ser_en = 1'b0;
        case (state_q)
            StStart: begin
                TX_OUT = 1'b0;
                busy   = 1'b1;
            end
            StData: begin
                TX_OUT = ser_data;
                busy   = 1'b1;
                ser_en = 1'b1;
            end
            StParity: begin
                TX_OUT = par_bit_q;
                busy   = 1'b1;
            end
            StStop: begin
                TX_OUT = 1'b1;
`ifdef UART_TX_B2B_EN
                busy   = 1'b0;
`else
                busy   = 1'b1;
`endif
            end
            default: begin
                TX_OUT = 1'b1;
                busy   = 1'b0;
            end
        endcase
    end

    // Next-state, watchdog and error-pulse logic.
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        frame_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StStart;
            end
            StStart: begin
                wdog_d  = '0;
                state_d = StData;
            end
            StData: begin
                wdog_d = wdog_q + 1'b1;
                // A late-but-valid ser_done beats the watchdog in the same cycle.
                if (ser_done) begin
                    state_d = par_en_q ? StParity : StStop;
                end else if (wdog_exp) begin
                    state_d     = StStop;
                    frame_err_d = 1'b1;
                end
            end
            StParity: begin
                state_d = StStop;
            end
            StStop: begin
                state_d = accept ? StStart : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched frame settings and error pulse; async active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            par_bit_q   <= 1'b0;
            par_en_q    <= 1'b0;
            wdog_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            frame_err_q <= frame_err_d;
            if (accept) begin
                par_bit_q <= (^P_DATA) ^ PAR_TYP;
                par_en_q  <= PAR_EN;
            end
        end
    end

    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl with a behavioural serializer
// stub. Honours UART_TX_B2B_EN for the STOP-phase busy and back-to-back case.
module tb_uart_tx_ctrl;

`ifdef UART_TX_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       busy;
    logic       TX_OUT;
    logic       frame_err;

    int checks = 0;
    int failures = 0;

    // Serializer stub state.
    logic [7:0] sh;
    logic [3:0] cnt;
    logic       stuck = 1'b0;

    uart_tx_ctrl #(
        .DATA_WIDTH(8),
        .WDOG_W    (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .ser_data  (ser_data),
        .ser_done  (ser_done),
        .ser_en    (ser_en),
        .busy      (busy),
        .TX_OUT    (TX_OUT),
        .frame_err (frame_err)
    );

    always #5 CLK = ~CLK;

    // Shift-register serializer: loads on accept, shifts on ser_en.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh  <= 8'h00;
            cnt <= 4'd0;
        end else if (Data_Valid && !busy) begin
            sh  <= P_DATA;
            cnt <= 4'd0;
        end else if (ser_en) begin
            sh  <= sh >> 1;
            cnt <= cnt + 4'd1;
        end
    end

    assign ser_data = sh[0];
    assign ser_done = !stuck && (cnt == 4'd7);

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_tx"}, TX_OUT, 1'b1);
        chk({tag, "_en"}, ser_en, 1'b0);
        chk({tag, "_err"}, frame_err, 1'b0);
    endtask

    // Present a word in IDLE and take the accept edge; Data_Valid stays high.
    task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        tick();
    endtask

    // Checks len cycles starting at START. tx_exp/err_exp are written in time
    // order with the first cycle as the most significant used bit.
    task automatic check_frame(input string tag, input int len, input logic [10:0] tx_exp,
                               input logic [10:0] err_exp, input bit toggle_pt);
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s_tx[%0d]", tag, i), TX_OUT, tx_exp[len-1-i]);
            chk($sformatf("%s_busy[%0d]", tag, i), busy,
                (i == len - 1) ? !B2B : 1'b1);
            chk($sformatf("%s_en[%0d]", tag, i), ser_en, (i >= 1 && i <= 8));
            chk($sformatf("%s_err[%0d]", tag, i), frame_err, err_exp[len-1-i]);
            if (toggle_pt) PAR_TYP = ~PAR_TYP;
            tick();
        end
    endtask

    initial begin
        // Reset state.
        #2;
        chk_idle("reset");
        tick();
        tick();
        chk_idle("reset_held");
        RST = 1'b1;
        tick();
        chk_idle("post_reset");

        // 0xA5 even parity: 11-cycle frame.
        accept(8'hA5, 1'b1, 1'b0);
        Data_Valid = 1'b0;
        check_frame("a5_even", 11, 11'b01010010101, 11'b0, 1'b0);
        chk_idle("a5_even_idle");

        // Asynchronous reset in the middle of DATA.
        accept(8'hA5, 1'b1, 1'b0);
        Data_Valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_pre_en", ser_en, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        chk_idle("mid_reset");
        tick();
        RST = 1'b1;
        tick();
        chk_idle("mid_released");
        accept(8'hA5, 1'b1, 1'b0);
        Data_Valid = 1'b0;
        check_frame("a5_after_rst", 11, 11'b01010010101, 11'b0, 1'b0);
        chk_idle("a5_after_rst_idle");

        // 0x01 odd parity -> parity bit 0.
        accept(8'h01, 1'b1, 1'b1);
        Data_Valid = 1'b0;
        check_frame("01_odd", 11, 11'b01000000001, 11'b0, 1'b0);
        chk_idle("01_odd_idle");

        // 0x01 without parity: 10 cycles.
        accept(8'h01, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        check_frame("01_nopar", 10, 11'b00100000001, 11'b0, 1'b0);
        chk_idle("01_nopar_idle");

        // PAR_TYP toggled mid-frame must not change the latched parity.
        accept(8'h0F, 1'b1, 1'b0);
        Data_Valid = 1'b0;
        check_frame("0f_toggle", 11, 11'b01111000001, 11'b0, 1'b1);
        PAR_TYP = 1'b0;
        chk_idle("0f_toggle_idle");

        // Watchdog: ser_done stuck low, error pulse in STOP, no parity slot.
        stuck = 1'b1;
        accept(8'hFF, 1'b1, 1'b0);
        Data_Valid = 1'b0;
        check_frame("wdog", 10, 11'b00111111111, 11'b00000000001, 1'b0);
        chk_idle("wdog_idle");
        stuck = 1'b0;

        // Data_Valid held across two frames.
        accept(8'h3C, 1'b0, 1'b0);
        P_DATA = 8'hC3;
        check_frame("b2b_f1", 10, 11'b00001111001, 11'b0, 1'b0);
`ifndef UART_TX_B2B_EN
        chk_idle("b2b_gap");
        tick();
`endif
        Data_Valid = 1'b0;
        check_frame("b2b_f2", 10, 11'b00110000111, 11'b0, 1'b0);
        chk_idle("b2b_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. It accepts a parallel word through a valid/busy handshake and computes its parity bit. It then drives the external shift-register serializer (load, shift enable, done) and emits the full line sequence on TX_OUT: start bit, data LSB first, optional parity, stop. It sits between the system-side producer and the TX pin, owning busy, ser_en and the output mux.

Parameters:
DATA_WIDTH, 8, data bits per frame; must match the serializer width.
WDOG_W, 4, width of the internal data-phase watchdog counter; must satisfy 2^WDOG_W > DATA_WIDTH.

Ports:
CLK  input  1  bit-rate clock; one TX bit per cycle.
RST  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_WIDTH  word to send; sampled on accept for the parity computation.
Data_Valid  input  1  producer request; accepted on a rising CLK edge when busy=0.
PAR_EN  input  1  parity enable; sampled on accept.
PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
ser_data  input  1  current serializer LSB.
ser_done  input  1  serializer is presenting the last data bit.
ser_en  output  1  serializer shift enable.
busy  output  1  frame in progress; the producer and serializer may load only when low.
TX_OUT  output  1  serial line, idles high.
frame_err  output  1  one-cycle pulse: watchdog expired in DATA.

Behaviour:
- Reset, asynchronous, immediate, including mid-frame:
  - state=IDLE, TX_OUT=1, busy=0, ser_en=0, frame_err=0.
  - Latched parity, PAR_EN and watchdog cleared.
- Moore FSM, states IDLE, START, DATA, PARITY, STOP. busy, ser_en and TX_OUT decode combinationally from the state register. frame_err is registered.
- IDLE:
  - TX_OUT=1, busy=0, ser_en=0.
  - Data_Valid=1 at an edge means accept: go to START, latch par_bit = ^P_DATA XOR PAR_TYP, latch PAR_EN. The serializer loads on the same edge.
  - Otherwise stay in IDLE.
- START:
  - TX_OUT=0, busy=1, ser_en=0. Exactly 1 cycle, then DATA. Watchdog is cleared on entry.
- DATA:
  - TX_OUT=ser_data, busy=1, ser_en=1. The watchdog increments each cycle.
  - ser_done=1: go to PARITY if the latched PAR_EN=1, else STOP. Nominal duration is DATA_WIDTH cycles.
  - Watchdog reaches DATA_WIDTH with ser_done still 0: go to STOP and pulse frame_err for 1 cycle. No parity bit is sent.
  - ser_done=1 and watchdog expiry in the same cycle: ser_done wins, no error.
- PARITY:
  - TX_OUT=par_bit, busy=1, ser_en=0. 1 cycle, then STOP.
- STOP:
  - TX_OUT=1, busy=1, ser_en=0. 1 cycle, then IDLE.
- Frame length while busy is 2+DATA_WIDTH+PAR_EN cycles: 11 with parity, 10 without (DATA_WIDTH=8).
- Data_Valid while busy=1 is ignored. The producer must hold it until a busy=0 edge.
- PAR_EN/PAR_TYP changes mid-frame have no effect on the current frame.
- Minimum idle gap between frames is 1 cycle (the IDLE accept cycle).

Optional Feature:
UART_TX_B2B_EN:
- Defined:
  - busy=0 during STOP, and Data_Valid=1 in STOP accepts the word.
  - The accept latches parity and goes STOP->START. The serializer loads on that edge.
  - Back-to-back frames then have no idle cycle between stop and start.
  - STOP with no Data_Valid goes to IDLE as normal.
- Undefined: behaviour exactly as above (busy=1 in STOP, STOP always returns to IDLE).

Test Plan:
- Reset mid-DATA: assert RST low -> TX_OUT=1, busy=0, ser_en=0 immediately; after release the next accept gives a normal frame.
- 0xA5 sent with PAR_EN=1, PAR_TYP=0 -> TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; busy high for exactly 11 cycles; ser_en high for exactly 8.
- 0x01 sent with PAR_EN=1, PAR_TYP=1 -> parity bit 0. The same word with PAR_EN=0 -> 10-cycle frame 0,1,0,0,0,0,0,0,0,1 with no parity slot.
- Data_Valid held high across a frame with 0x3C then 0xC3 on P_DATA -> second frame starts only after an IDLE cycle with busy=0; with UART_TX_B2B_EN, START immediately follows STOP.
- Serializer stub with ser_done stuck at 0 -> after 8 DATA cycles frame_err=1 for one cycle, then STOP (TX_OUT=1) and IDLE; no parity bit sent.
- PAR_TYP toggled during DATA of frame 0x0F (PAR_EN=1, PAR_TYP=0 at accept) -> parity bit stays 0.
